// File: rtl/ysyx_041461_pipe_skid_reg_pkg.sv
// ysyx_041461_pipe_skid_reg_pkg: occupancy encodings and shared payload constants for the elastic pipeline register
package ysyx_041461_pipe_skid_reg_pkg;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
  localparam logic [63:0] PC_RST = 64'h0000_0000_3000_0000;
endpackage

// File: rtl/ysyx_041461_pipe_skid_reg_if.sv
// ysyx_041461_pipe_skid_reg_if: stage handshake bundle (flush, in valid/ready/data, out valid/ready/data, occupancy); master drives upstream/downstream side, slave is the register
interface ysyx_041461_pipe_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/ysyx_041461_pipe_slot.sv
// ysyx_041461_pipe_slot: valid bit plus payload register; clk/rst, load sets valid and captures d, clr drops valid, outputs valid and q (RST_DATA after reset)
module ysyx_041461_pipe_slot #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) valid <= 1'b0;
    else if (load) valid <= 1'b1;
    else if (clr) valid <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) q <= RST_DATA;
    else if (load) q <= d;
  end
endmodule

// File: rtl/ysyx_041461_pipe_skid_reg.sv
// ysyx_041461_pipe_skid_reg: elastic pipeline register with flush and optional 2-entry skid; ports clk, rst and slave handshake bundle p
module ysyx_041461_pipe_skid_reg
  import ysyx_041461_pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter bit                SKID     = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_041461_pipe_skid_reg_if.slave p
);
  logic              in_fire, out_fire, main_v, main_ld, main_clr;
  logic [DATA_W-1:0] main_d;
  assign in_fire   = p.in_valid & p.in_ready;
  assign out_fire  = main_v & p.out_ready;
  assign p.out_valid = main_v;
  ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
    .clk(clk), .rst(rst), .load(main_ld), .clr(main_clr), .d(main_d), .valid(main_v), .q(p.out_data)
  );
  generate
    if (SKID) begin : g_skid
      occ_e              st, st_n;
      logic              skid_v, skid_ld, skid_clr;
      logic [DATA_W-1:0] skid_q;
      ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
        .clk(clk), .rst(rst), .load(skid_ld), .clr(skid_clr), .d(p.in_data), .valid(skid_v), .q(skid_q)
      );
      always_ff @(posedge clk) st <= rst ? OCC_EMPTY : st_n;
      // A held skid entry always refills main first, keeping FIFO order; in_ready is the registered !skid_v.
      always_comb begin
        st_n     = p.flush ? OCC_EMPTY : occ_e'(st + {1'b0, in_fire} - {1'b0, out_fire});
        main_ld  = !p.flush & (skid_v ? out_fire : in_fire & (!main_v | out_fire));
        main_d   = skid_v ? skid_q : p.in_data;
        main_clr = p.flush | out_fire;
        skid_ld  = !p.flush & in_fire & main_v & !out_fire;
        skid_clr = p.flush | out_fire;
      end
      assign p.in_ready  = !skid_v;
      assign p.occupancy = st;
    end else begin : g_single
      always_comb begin
        main_ld  = !p.flush & in_fire;
        main_clr = p.flush | out_fire;
        main_d   = p.in_data;
      end
      assign p.in_ready  = !main_v | p.out_ready;
      assign p.occupancy = {1'b0, main_v};
    end
  endgenerate
endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// tb_ysyx_041461_pipe_skid_reg: directed vector bench for both skid and single-entry builds
module tb_ysyx_041461_pipe_skid_reg;
  typedef struct {
    logic        r, f, iv;
    logic [63:0] d;
    logic        o, chk, eov;
    logic [63:0] eod;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;
  logic clk = 1'b0, rst;
  int   n_vec = 0, n_err = 0;
  vec_t tbl[$];
  ysyx_041461_pipe_skid_reg_if #(.DATA_W(64)) i1 ();
  ysyx_041461_pipe_skid_reg_if #(.DATA_W(64)) i0 ();
  ysyx_041461_pipe_skid_reg #(.DATA_W(64), .RST_DATA(64'h0), .SKID(1'b1)) dut1 (.clk(clk), .rst(rst), .p(i1));
  ysyx_041461_pipe_skid_reg #(.DATA_W(64), .RST_DATA(64'h0), .SKID(1'b0)) dut0 (.clk(clk), .rst(rst), .p(i0));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic f, logic iv, logic [63:0] d, logic o, logic chk,
                              logic eov, logic [63:0] eod, logic [1:0] eocc, logic eir);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.o = o; v.chk = chk;
    v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
    return v;
  endfunction
  task automatic drive(input logic r, input logic f, input logic iv, input logic [63:0] d, input logic o);
    rst = r;
    i1.flush = f; i1.in_valid = iv; i1.in_data = d; i1.out_ready = o;
    i0.flush = f; i0.in_valid = iv; i0.in_data = d; i0.out_ready = o;
  endtask
  task automatic check(input string nm, input logic ov, input logic [63:0] od, input logic [1:0] oc,
                       input logic ir, input vec_t v);
    n_vec++;
    if (ov !== v.eov || od !== v.eod || oc !== v.eocc || ir !== v.eir) begin
      n_err++;
      $display("FAIL %s: got valid=%0b data=%0h occ=%0d ready=%0b, want valid=%0b data=%0h occ=%0d ready=%0b",
               nm, ov, od, oc, ir, v.eov, v.eod, v.eocc, v.eir);
    end
  endtask
  task automatic run(input bit sel, input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].o);
      @(negedge clk);
      if (tbl[i].chk) begin
        if (sel) check($sformatf("%s[%0d]", tag, i), i1.out_valid, i1.out_data, i1.occupancy, i1.in_ready, tbl[i]);
        else     check($sformatf("%s[%0d]", tag, i), i0.out_valid, i0.out_data, i0.occupancy, i0.in_ready, tbl[i]);
      end
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask
  initial begin
    int sent, got, cyc;
    // skid build: reset, streaming, back-pressure, flush, reset mid-operation
    tbl.push_back(mk(1,0,1,64'hAA,0, 0, 0,0,0,1));
    tbl.push_back(mk(1,0,1,64'hAA,0, 1, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 0,0,0,1));
    tbl.push_back(mk(0,0,1,1,1,      1, 0,0,0,1));
    tbl.push_back(mk(0,0,1,2,1,      1, 1,1,1,1));
    tbl.push_back(mk(0,0,1,3,1,      1, 1,2,1,1));
    tbl.push_back(mk(0,0,1,4,1,      1, 1,3,1,1));
    tbl.push_back(mk(0,0,0,0,1,      1, 1,4,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 0,4,0,1));
    tbl.push_back(mk(0,0,1,10,1,     1, 0,4,0,1));
    tbl.push_back(mk(0,0,1,11,0,     1, 1,10,1,1));
    tbl.push_back(mk(0,0,1,12,0,     1, 1,10,2,0));
    tbl.push_back(mk(0,0,1,12,0,     1, 1,10,2,0));
    tbl.push_back(mk(0,0,1,12,1,     1, 1,10,2,0));
    tbl.push_back(mk(0,0,1,12,1,     1, 1,11,1,1));
    tbl.push_back(mk(0,0,0,0,1,      1, 1,12,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 0,12,0,1));
    tbl.push_back(mk(0,0,1,20,0,     1, 0,12,0,1));
    tbl.push_back(mk(0,0,1,21,0,     1, 1,20,1,1));
    tbl.push_back(mk(0,1,1,22,0,     1, 1,20,2,0));
    tbl.push_back(mk(0,0,0,0,1,      1, 0,20,0,1));
    tbl.push_back(mk(0,0,0,0,1,      1, 0,20,0,1));
    tbl.push_back(mk(0,0,1,30,1,     1, 0,20,0,1));
    tbl.push_back(mk(0,1,1,31,1,     1, 1,30,1,1));
    tbl.push_back(mk(0,0,0,0,1,      1, 0,30,0,1));
    tbl.push_back(mk(0,0,1,40,0,     1, 0,30,0,1));
    tbl.push_back(mk(1,1,1,41,0,     1, 1,40,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 0,0,0,1));
    run(1'b1, "skid");
    // single-entry build: out_ready 1,0,1 with 5,6,7; in_ready follows out_ready combinationally
    tbl.push_back(mk(1,0,0,0,1,      0, 0,0,0,1));
    tbl.push_back(mk(0,0,1,5,1,      1, 0,0,0,1));
    tbl.push_back(mk(0,0,1,6,0,      1, 1,5,1,0));
    tbl.push_back(mk(0,0,1,6,1,      1, 1,5,1,1));
    tbl.push_back(mk(0,0,1,7,1,      1, 1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 1,7,1,0));
    tbl.push_back(mk(0,0,0,0,1,      1, 1,7,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1, 0,7,0,1));
    run(1'b0, "single");
    // skid build: random downstream stalls, payloads must emerge in order, once each
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 400) begin
      drive(0, 0, sent < 20, 64'(100 + sent), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (i1.in_valid && i1.in_ready) sent++;
      if (i1.out_valid && i1.out_ready) begin
        n_vec++;
        if (i1.out_data !== 64'(100 + got)) begin
          n_err++;
          $display("FAIL stream[%0d]: got data=%0h, want data=%0h", got, i1.out_data, 64'(100 + got));
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (got != 20) begin
      n_err++;
      $display("FAIL stream_done: got %0d payloads, want 20 within 400 cycles", got);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
